// File: rtl/mem_stage_pkg.sv
// Shared encodings and helpers for the MEM pipeline stage: access sizes,
// the stage FSM states, and byte-enable / store-data lane generation.
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    function automatic logic [3:0] gen_be(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 4'b0001 << addr_lo;
            SZ_HALF: return 4'b0011 << addr_lo;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] gen_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SZ_BYTE: return {4{data[7:0]}};
            SZ_HALF: return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    // Reserved size 11 is never legal; halves need an even address, words a 4-byte one.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return !addr_lo[0];
            SZ_WORD: return addr_lo == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half lane out of a 32-bit read word and
// sign- or zero-extends it to a full register value.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: data = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
            SZ_HALF: data = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: passes ALU ops straight through, runs loads/stores over a
// req/rsp data-memory handshake with a timeout, and stalls upstream meanwhile.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_mem_unsigned,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic        ex_reg_write,
    input  logic        ex_mem_to_reg,
    input  logic [4:0]  ex_reg_dest,
    output logic        stall_out,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic        wb_mem_to_reg,
    output logic [4:0]  wb_reg_dest,
    output logic [31:0] wb_result,
    output logic [31:0] wb_load_data,
    output logic        misalign_exc,
    output logic        bus_error
);

    localparam logic [7:0] TIMER_LAST = 8'(MAX_WAIT - 1);

    state_t      state;
    logic [7:0]  timer;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        is_load_q;
    logic        reg_write_q;
    logic        mem_to_reg_q;
    logic [4:0]  dest_q;
    logic [31:0] load_q;
    logic        timeout_q;

    logic        mem_op;
    logic        aligned;
    logic        expired;
    logic [31:0] aligned_rdata;

    assign mem_op  = ex_valid && (ex_mem_read || ex_mem_write);
    assign aligned = is_aligned(ex_mem_size, ex_alu_result[1:0]);
    // Budget covers REQ and WAIT together; a WAIT entered on the last REQ cycle expires at once.
    assign expired = timer >= TIMER_LAST;

    load_align u_load_align (
        .rdata       (dmem_rdata),
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (aligned_rdata)
    );

    always_ff @(posedge clk) begin
        // NOTE: nonblocking assignments so every register samples pre-edge values.
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            is_load_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            dest_q       <= '0;
            load_q       <= '0;
            timeout_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op && aligned) begin
                        addr_q       <= ex_alu_result;
                        wdata_q      <= gen_wdata(ex_mem_size, ex_store_data);
                        be_q         <= gen_be(ex_mem_size, ex_alu_result[1:0]);
                        size_q       <= ex_mem_size;
                        uns_q        <= ex_mem_unsigned;
                        is_load_q    <= ex_mem_read;
                        reg_write_q  <= ex_reg_write;
                        mem_to_reg_q <= ex_mem_to_reg;
                        dest_q       <= ex_reg_dest;
                        load_q       <= '0;
                        timeout_q    <= 1'b0;
                        timer        <= '0;
                        state        <= REQ;
                    end
                end
                REQ: begin
                    timer <= timer + 8'd1;
                    if (dmem_req_ready) begin
                        state <= is_load_q ? WAIT : DONE;
                    end else if (expired) begin
                        timeout_q <= 1'b1;
                        state     <= DONE;
                    end
                end
                WAIT: begin
                    timer <= timer + 8'd1;
                    if (dmem_rsp_valid) begin
                        load_q <= aligned_rdata;
                        state  <= DONE;
                    end else if (expired) begin
                        timeout_q <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        stall_out      = 1'b0;
        dmem_req_valid = 1'b0;
        dmem_we        = 1'b0;
        dmem_addr      = '0;
        dmem_wdata     = '0;
        dmem_be        = '0;
        wb_valid       = 1'b0;
        wb_reg_write   = 1'b0;
        wb_mem_to_reg  = 1'b0;
        wb_reg_dest    = '0;
        wb_result      = '0;
        wb_load_data   = '0;
        misalign_exc   = 1'b0;
        bus_error      = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (ex_valid && (!mem_op || !aligned)) begin
                        wb_valid      = 1'b1;
                        wb_reg_write  = ex_reg_write && !mem_op;
                        wb_mem_to_reg = ex_mem_to_reg;
                        wb_reg_dest   = ex_reg_dest;
                        wb_result     = ex_alu_result;
                        misalign_exc  = mem_op;
                    end else if (mem_op) begin
                        stall_out = 1'b1;
                    end
                end
                REQ: begin
                    stall_out      = 1'b1;
                    dmem_req_valid = 1'b1;
                    dmem_we        = !is_load_q;
                    dmem_addr      = {addr_q[31:2], 2'b00};
                    dmem_wdata     = wdata_q;
                    dmem_be        = be_q;
                end
                WAIT: stall_out = 1'b1;
                default: begin
                    wb_valid      = 1'b1;
                    wb_reg_write  = reg_write_q && !timeout_q;
                    wb_mem_to_reg = mem_to_reg_q;
                    wb_reg_dest   = dest_q;
                    wb_result     = addr_q;
                    wb_load_data  = load_q;
                    bus_error     = timeout_q;
                end
            endcase
        end
    end

endmodule
